// File: rtl/onehot_index_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : onehot_index_scanner
//  Purpose  : Accepts an N_IN-bit request vector over valid/ready and emits the
//             binary index of every set bit, one per cycle, in priority order
//             (LSB_FIRST selects lowest- or highest-bit-first) over a second
//             valid/ready handshake. All-zero vectors raise a one-cycle
//             empty_err pulse instead of producing indices.
//  Options  : SCAN_COUNT_EN - adds pop_cnt, the registered popcount of the
//             accepted vector, held constant for the duration of the scan.
//  Revision : 1.0 - initial release
// ============================================================================
module onehot_index_scanner #(
  parameter int N_IN      = 8,
  parameter int LSB_FIRST = 1,
  localparam int IDX_W    = $clog2(N_IN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  in_vec,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] idx,
  output logic             idx_valid,
  input  logic             idx_ready,
  output logic             idx_last,
  output logic             empty_err,
`ifdef SCAN_COUNT_EN
  output logic [IDX_W:0]   pop_cnt,
`endif
  output logic             busy
);

  localparam logic [N_IN-1:0] c_ONE = {{(N_IN-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   pending_q, pending_d;
  logic              err_q, err_d;

  logic [IDX_W-1:0]  sel_idx_w;
  logic [N_IN-1:0]   sel_mask_w;
  logic              single_w;

  // Priority pick of the bit to emit next; only pending_q feeds it, so the
  // index output never depends combinationally on any input port.
  generate
    if (LSB_FIRST != 0) begin : g_lsb_first
      // Lowest set bit wins: walk downward so the last hit is the lowest.
      always_comb begin
        sel_idx_w = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
          if (pending_q[i]) begin
            sel_idx_w = IDX_W'(i);
          end
        end
      end
    end else begin : g_msb_first
      // Highest set bit wins: walk upward so the last hit is the highest.
      always_comb begin
        sel_idx_w = '0;
        for (int i = 0; i < N_IN; i++) begin
          if (pending_q[i]) begin
            sel_idx_w = IDX_W'(i);
          end
        end
      end
    end
  endgenerate

  // Mask of the selected bit and "exactly one bit left" detection.
  always_comb begin
    sel_mask_w = c_ONE << sel_idx_w;
    single_w   = (pending_q != '0) && ((pending_q & (pending_q - c_ONE)) == '0);
  end

`ifdef SCAN_COUNT_EN
  logic [IDX_W:0] pop_cnt_q, pop_cnt_d;
  logic [IDX_W:0] in_pop_w;

  // Population count of the incoming vector, captured on acceptance.
  always_comb begin
    in_pop_w = '0;
    for (int i = 0; i < N_IN; i++) begin
      in_pop_w = in_pop_w + (IDX_W + 1)'(in_vec[i]);
    end
  end
`endif

  // Next-state logic: accept in IDLE, retire one bit per handshake in SCAN.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    err_d     = 1'b0;
`ifdef SCAN_COUNT_EN
    pop_cnt_d = pop_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          pending_d = in_vec;
          err_d     = (in_vec == '0);
          if (in_vec != '0) begin
            state_d = SCAN;
`ifdef SCAN_COUNT_EN
            pop_cnt_d = in_pop_w;
`endif
          end
        end
      end
      SCAN: begin
        if (idx_ready) begin
          pending_d = pending_q & ~sel_mask_w;
          if (single_w) begin
            state_d = IDLE;
`ifdef SCAN_COUNT_EN
            pop_cnt_d = '0;
`endif
          end
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      err_q     <= 1'b0;
`ifdef SCAN_COUNT_EN
      pop_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      err_q     <= err_d;
`ifdef SCAN_COUNT_EN
      pop_cnt_q <= pop_cnt_d;
`endif
    end
  end

  // Output decode, purely from registered state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q == SCAN);
    idx_valid = (state_q == SCAN);
    idx       = sel_idx_w;
    idx_last  = (state_q == SCAN) && single_w;
    empty_err = err_q;
`ifdef SCAN_COUNT_EN
    pop_cnt   = pop_cnt_q;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_onehot_index_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_onehot_index_scanner
//  Purpose  : Self-checking bench for onehot_index_scanner. Three instances
//             (N_IN=8 LSB-first, N_IN=8 MSB-first, N_IN=5 MSB-first) share
//             stimulus; a list-based reference model predicts every output.
//             Honours SCAN_COUNT_EN when defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_onehot_index_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_vec;
  logic       in_valid;
  logic       idx_ready;

  logic       ir0, iv0, il0, ee0, b0;
  logic       ir1, iv1, il1, ee1, b1;
  logic       ir2, iv2, il2, ee2, b2;
  logic [2:0] idx0, idx1, idx2;
  logic [3:0] pc0, pc1, pc2;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  onehot_index_scanner #(.N_IN(8), .LSB_FIRST(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid),
    .in_ready(ir0), .idx(idx0), .idx_valid(iv0), .idx_ready(idx_ready),
    .idx_last(il0), .empty_err(ee0),
`ifdef SCAN_COUNT_EN
    .pop_cnt(pc0),
`endif
    .busy(b0));

  onehot_index_scanner #(.N_IN(8), .LSB_FIRST(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid),
    .in_ready(ir1), .idx(idx1), .idx_valid(iv1), .idx_ready(idx_ready),
    .idx_last(il1), .empty_err(ee1),
`ifdef SCAN_COUNT_EN
    .pop_cnt(pc1),
`endif
    .busy(b1));

  onehot_index_scanner #(.N_IN(5), .LSB_FIRST(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_vec(in_vec[4:0]), .in_valid(in_valid),
    .in_ready(ir2), .idx(idx2), .idx_valid(iv2), .idx_ready(idx_ready),
    .idx_last(il2), .empty_err(ee2),
`ifdef SCAN_COUNT_EN
    .pop_cnt(pc2),
`endif
    .busy(b2));

`ifndef SCAN_COUNT_EN
  assign pc0 = '0;
  assign pc1 = '0;
  assign pc2 = '0;
`endif

  // ---------------- reference model ----------------
  // Each accepted vector becomes an ordered list of set-bit indices; the
  // model emits the list head and drops it on every downstream handshake.
  int nin  [3] = '{8, 8, 5};
  bit lsbf [3] = '{1'b1, 1'b0, 1'b0};
  int mlist[3][8];
  int mhead[3];
  int mcnt [3];
  bit mbusy[3];
  bit merr [3];
  int mpop [3];

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      int vi;
      vi = int'(in_vec) & ((1 << nin[d]) - 1);
      if (!rst_n) begin
        mbusy[d] = 1'b0; merr[d] = 1'b0; mpop[d] = 0;
        mhead[d] = 0;    mcnt[d] = 0;
      end else if (!mbusy[d]) begin
        merr[d] = in_valid && (vi == 0);
        if (in_valid && vi != 0) begin
          mhead[d] = 0;
          mcnt[d]  = 0;
          for (int k = 0; k < nin[d]; k++) begin
            int b;
            b = lsbf[d] ? k : (nin[d] - 1 - k);
            if (((vi >> b) & 1) == 1) begin
              mlist[d][mcnt[d]] = b;
              mcnt[d] = mcnt[d] + 1;
            end
          end
          mpop[d]  = mcnt[d];
          mbusy[d] = 1'b1;
        end
      end else begin
        merr[d] = 1'b0;
        if (idx_ready) begin
          mhead[d] = mhead[d] + 1;
          if (mhead[d] == mcnt[d]) begin
            mbusy[d] = 1'b0; mpop[d] = 0; mhead[d] = 0; mcnt[d] = 0;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cmp_dut(input int d, input logic ir, input logic [2:0] ix,
                         input logic iv, input logic il, input logic ee,
                         input logic bz, input logic [3:0] pc);
    int e_idx;
    e_idx = mbusy[d] ? mlist[d][mhead[d]] : 0;
    check($sformatf("d%0d_in_ready", d), {31'd0, ir}, {31'd0, !mbusy[d]});
    check($sformatf("d%0d_busy", d),     {31'd0, bz}, {31'd0, mbusy[d]});
    check($sformatf("d%0d_idx_valid", d),{31'd0, iv}, {31'd0, mbusy[d]});
    check($sformatf("d%0d_idx", d),      {29'd0, ix}, e_idx);
    check($sformatf("d%0d_idx_last", d), {31'd0, il},
          {31'd0, mbusy[d] && (mcnt[d] - mhead[d] == 1)});
    check($sformatf("d%0d_empty_err", d),{31'd0, ee}, {31'd0, merr[d]});
    check($sformatf("d%0d_idx_range", d),{31'd0, (int'(ix) < nin[d])}, 32'd1);
`ifdef SCAN_COUNT_EN
    check($sformatf("d%0d_pop_cnt", d),  {28'd0, pc}, mpop[d]);
`else
    if (pc !== 4'd0) check($sformatf("d%0d_pop_tie", d), {28'd0, pc}, 32'd0);
`endif
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut(0, ir0, idx0, iv0, il0, ee0, b0, pc0);
      cmp_dut(1, ir1, idx1, iv1, il1, ee1, b1, pc1);
      cmp_dut(2, ir2, idx2, iv2, il2, ee2, b2, pc2);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic [7:0] v, input logic vld, input logic rdy);
    in_vec = v; in_valid = vld; idx_ready = rdy;
  endtask

  // Literal check of both 8-bit instances' index, valid and last flags.
  task automatic lit(input string name, input int i0, input int i1,
                     input bit v, input bit l0, input bit l1);
    check({name, "_idx0"},  {29'd0, idx0}, i0);
    check({name, "_idx1"},  {29'd0, idx1}, i1);
    check({name, "_vld0"},  {31'd0, iv0}, {31'd0, v});
    check({name, "_vld1"},  {31'd0, iv1}, {31'd0, v});
    check({name, "_last0"}, {31'd0, il0}, {31'd0, l0});
    check({name, "_last1"}, {31'd0, il1}, {31'd0, l1});
  endtask

  initial begin
    rst_n = 1'b0;
    drive(8'h00, 1'b0, 1'b0);
    tick(); tick();
    // Reset state
    check("rst_in_ready", {31'd0, ir0}, 32'd1);
    check("rst_idx_valid", {31'd0, iv0}, 32'd0);
    check("rst_idx", {29'd0, idx0}, 32'd0);
    check("rst_busy", {31'd0, b0}, 32'd0);
    check("rst_empty_err", {31'd0, ee0}, 32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    tick();

    // One-hot 0x20
    drive(8'h20, 1'b1, 1'b1); tick();
    lit("onehot", 5, 5, 1, 1, 1);
    drive(8'h00, 1'b0, 1'b1); tick();
    check("onehot_ready_after", {31'd0, ir0}, 32'd1);

    // Multi-hot 0x85
    drive(8'h85, 1'b1, 1'b1); tick();
    lit("multi_a", 0, 7, 1, 0, 0);
    drive(8'h00, 1'b0, 1'b1); tick();
    lit("multi_b", 2, 2, 1, 0, 0);
    tick();
    lit("multi_c", 7, 0, 1, 1, 1);
    tick();
    check("multi_idle", {31'd0, ir1}, 32'd1);

    // Backpressure 0x0A
    drive(8'h0A, 1'b1, 1'b0); tick();
    drive(8'h00, 1'b0, 1'b0);
    for (int s = 0; s < 3; s++) begin
      lit("stall", 1, 3, 1, 0, 0);
      if (s < 2) tick();
    end
    idx_ready = 1'b1; tick();
    lit("stall_rel", 3, 1, 1, 1, 1);
    tick();

    // Empty vector
    drive(8'h00, 1'b1, 1'b1); tick();
    check("empty_err0", {31'd0, ee0}, 32'd1);
    check("empty_vld0", {31'd0, iv0}, 32'd0);
    check("empty_rdy0", {31'd0, ir0}, 32'd1);
    drive(8'h00, 1'b0, 1'b1); tick();
    check("empty_pulse_end", {31'd0, ee0}, 32'd0);

    // Mid-scan reset on 0xFF
    drive(8'hFF, 1'b1, 1'b1); tick();
    lit("mid_first", 0, 7, 1, 0, 0);
`ifdef SCAN_COUNT_EN
    check("mid_pop_scan", {28'd0, pc0}, 32'd8);
`endif
    drive(8'h00, 1'b0, 1'b1); tick();
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    check("mid_rst_vld", {31'd0, iv0}, 32'd0);
    check("mid_rst_rdy", {31'd0, ir0}, 32'd1);
`ifdef SCAN_COUNT_EN
    check("mid_rst_pop", {28'd0, pc0}, 32'd0);
`endif
    tick();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      in_vec    = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      idx_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 249) != 0);
      tick();
    end
    rst_n = 1'b1;
    drive(8'h00, 1'b0, 1'b1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
